// File: rtl/harmonic_mean_ctrl.sv
// Four-channel harmonic-mean sequencer: 4/(1/x1+1/x2+1/x3+1/x4) on one shared restoring divider.
// Optional hit counters (stat_done, stat_zero) are enabled by defining HARMONIC_MEAN_CTRL_STATS_EN.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_COLLECT  | accept one sample per channel, ch_ready = ~captured
// S_CHECK    | zero-sample screen; zero -> S_OUT, else start reciprocals
// S_RECIP_LD | load divider with 2^(2DW-1) / x[idx]
// S_RECIP    | N divider iterations; accumulate reciprocal into sum
// S_FINAL_LD | load divider with 2^(2DW+1) / sum
// S_FINAL    | N divider iterations; saturate quotient into result
// S_OUT      | hold result/zero_err valid until result_ready

module harmonic_mean_ctrl #(
   parameter int DW = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [4*DW-1:0] ch_data,
   input  logic [3:0]      ch_valid,
   output logic [3:0]      ch_ready,
   output logic [DW-1:0]   result,
   output logic            result_valid,
   input  logic            result_ready,
   output logic            zero_err
`ifdef HARMONIC_MEAN_CTRL_STATS_EN
   ,
   output logic [31:0]     stat_done,
   output logic [31:0]     stat_zero
`endif
);

   localparam int N  = 2*DW + 2;
   localparam int CW = $clog2(N);
   localparam logic [N-1:0]  RECIP_DVD = N'(1) << (2*DW - 1);
   localparam logic [N-1:0]  FINAL_DVD = N'(1) << (2*DW + 1);
   localparam logic [CW-1:0] CNT_LOAD  = CW'(N - 1);

   typedef enum logic [2:0] {
      S_COLLECT,
      S_CHECK,
      S_RECIP_LD,
      S_RECIP,
      S_FINAL_LD,
      S_FINAL,
      S_OUT
   } state_t;

   state_t          state, state_n;
   logic [3:0]      captured, captured_n, ch_ready_n, xfer;
   logic [DW-1:0]   x [4];
   logic [1:0]      idx;
   logic [N-1:0]    sum, rem, quo, dvs;
   logic [N-1:0]    trial, rem_n, quo_n;
   logic [CW-1:0]   cnt;
   logic            ge, tc, any_zero, accept;

   assign xfer         = ch_valid & ch_ready;
   assign result_valid = (state == S_OUT);
   assign accept       = result_valid & result_ready;
   assign tc           = (cnt == '0);

   always_comb begin
      any_zero = 1'b0;
      for (int i = 0; i < 4; i++)
         if (x[i] == '0) any_zero = 1'b1;
   end

   // One restoring step: shift the next dividend bit into the remainder, subtract if it fits.
   always_comb begin
      trial = {rem[N-2:0], quo[N-1]};
      ge    = (trial >= dvs);
      rem_n = ge ? (trial - dvs) : trial;
      quo_n = {quo[N-2:0], ge};
   end

   always_comb begin
      state_n    = state;
      captured_n = captured;
      case (state)
         S_COLLECT: begin
            captured_n = captured | xfer;
            if (&captured) state_n = S_CHECK;
         end
         S_CHECK:    state_n = any_zero ? S_OUT : S_RECIP_LD;
         S_RECIP_LD: state_n = S_RECIP;
         S_RECIP:    if (tc) state_n = (idx == 2'd3) ? S_FINAL_LD : S_RECIP_LD;
         S_FINAL_LD: state_n = S_FINAL;
         S_FINAL:    if (tc) state_n = S_OUT;
         S_OUT: begin
            if (result_ready) begin
               state_n    = S_COLLECT;
               captured_n = '0;
            end
         end
         default:    state_n = S_COLLECT;
      endcase
      ch_ready_n = (state_n == S_COLLECT) ? ~captured_n : 4'b0000;
   end

   // ch_ready is registered so it reads 0 in the cycle right after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_COLLECT;
         captured <= '0;
         ch_ready <= '0;
      end else begin
         state    <= state_n;
         captured <= captured_n;
         ch_ready <= ch_ready_n;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) x[i] <= '0;
         result   <= '0;
         zero_err <= 1'b0;
         idx      <= '0;
         sum      <= '0;
         rem      <= '0;
         quo      <= '0;
         dvs      <= '0;
         cnt      <= '0;
      end else begin
         for (int i = 0; i < 4; i++)
            if (xfer[i]) x[i] <= ch_data[i*DW +: DW];
         case (state)
            S_CHECK: begin
               if (any_zero) begin
                  result   <= '0;
                  zero_err <= 1'b1;
               end else begin
                  sum <= '0;
                  idx <= '0;
               end
            end
            S_RECIP_LD: begin
               rem <= '0;
               quo <= RECIP_DVD;
               dvs <= N'(x[idx]);
               cnt <= CNT_LOAD;
            end
            S_RECIP: begin
               rem <= rem_n;
               quo <= quo_n;
               cnt <= cnt - CW'(1);
               if (tc) begin
                  sum <= sum + quo_n;
                  idx <= idx + 2'd1;
               end
            end
            S_FINAL_LD: begin
               rem <= '0;
               quo <= FINAL_DVD;
               dvs <= sum;
               cnt <= CNT_LOAD;
            end
            S_FINAL: begin
               rem <= rem_n;
               quo <= quo_n;
               cnt <= cnt - CW'(1);
               if (tc) begin
                  result   <= (|quo_n[N-1:DW]) ? {DW{1'b1}} : quo_n[DW-1:0];
                  zero_err <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef HARMONIC_MEAN_CTRL_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_done <= '0;
         stat_zero <= '0;
      end else if (accept) begin
         stat_done <= stat_done + 32'd1;
         if (zero_err) stat_zero <= stat_zero + 32'd1;
      end
   end
`else
   logic unused_accept;
   assign unused_accept = accept;
`endif

endmodule
